// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder/subtractor controller:
// FSM state encoding, default operand width and counter sizing helper.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The bit counter has to reach WIDTH itself (not just WIDTH-1),
    // so it is sized for WIDTH+1 distinct values.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module adder_1bit (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic Co,
    output logic S
);

    // Sum and carry of one bit position.
    always_comb begin
        S  = A ^ B ^ Ci;
        Co = (A & B) | (Ci & (A ^ B));
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller. Operands are captured on an accepted
// start, then one bit per clock is pushed LSB-first through a single full
// adder; the result is shifted into sum from the MSB side.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow
// output ovf.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; sum/cout (and ovf) hold the last result
// RUN     | one bit per cycle through the adder; extra cycle at cnt==WIDTH
// DONE    | done pulse for one cycle, then back to IDLE unconditionally
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             done_q;
    logic             busy_q;
`ifdef SERIAL_ADD_OVF_EN
    logic             cmsb_q;
    logic             ovf_q;
`endif

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] a_d;
    logic [WIDTH-1:0] b_d;
    logic [CNT_W-1:0] cnt_d;

    adder_1bit u_fa (
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Ci (carry_q),
        .Co (fa_co),
        .S  (fa_s)
    );

    // Shifted operand/result values for the next processed bit.
    always_comb begin
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CNT_ONE;
    end

    // Controller FSM with registered outputs and serial datapath registers.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            cmsb_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        // Subtraction is A + ~B + 1; cin is ignored then.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == CNT_END) begin
                        // All bits processed; carry_q is the final carry.
                        cout_q  <= carry_q;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`ifdef SERIAL_ADD_OVF_EN
                        ovf_q   <= cmsb_q ^ carry_q;
`endif
                    end else begin
                        a_q     <= a_d;
                        b_q     <= b_d;
                        sum_q   <= sum_d;
                        carry_q <= fa_co;
                        cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
                        // Remember the carry going into the MSB position.
                        if (cnt_q == CNT_MSB) begin
                            cmsb_q <= carry_q;
                        end
`endif
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8). Stimulus pushes the
// expected result of each accepted operation; a monitor pops and compares
// on every done pulse.
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int unsigned MASK = (1 << W) - 1;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rstb  (rstb),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    logic [W-1:0] last_sum;
    logic         last_cout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's meaning.
    function automatic exp_t model(input int unsigned av, input int unsigned bv,
                                   input bit sv, input bit cv, input int acc);
        exp_t e;
        int unsigned bb, c, tot;
        int sa, sb, r;
        bb  = sv ? (~bv & MASK) : bv;
        c   = sv ? 1 : int'(cv);
        tot = av + bb + c;
        e.sum  = W'(tot & MASK);
        e.cout = ((tot >> W) & 1) != 0;
        sa = (av >= (1 << (W-1))) ? int'(av) - (1 << W) : int'(av);
        sb = (bb >= (1 << (W-1))) ? int'(bb) - (1 << W) : int'(bb);
        r  = sa + sb + int'(c);
        e.ovf = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
        e.acc = acc;
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (rstb === 1'b1 && done === 1'b1) begin
            n_done++;
            if (sbq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done actual=done required=no_done (t=%0t)", $time);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sum", 32'(sum), 32'(e.sum));
                chk("cout", 32'(cout), 32'(e.cout));
                chk("latency", 32'(cyc - e.acc), 32'(LAT));
                chk("busy_in_done", 32'(busy), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
                last_sum  = e.sum;
                last_cout = e.cout;
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Start one operation, then scramble the inputs while it runs.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit sv, input bit cv);
        wait_idle();
        a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
        @(negedge clk);
        sbq.push_back(model(av, bv, sv, cv, cyc));
        start = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        cin = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sum"}, 32'(sum), 32'd0);
        chk({tag, "_cout"}, 32'(cout), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
    endtask

    initial begin
        int d0;
        // Reset with start held high: start must be ignored.
        rstb = 1'b0;
        start = 1'b1;
        a = 8'h11; b = 8'h22;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rstb = 1'b1;
        start = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", 32'(busy), 32'd0);

        // Directed arithmetic cases.
        issue(8'h2A, 8'h15, 1'b0, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(sum), 32'h3F);
        chk("hold_cout", 32'(cout), 32'd0);
        issue(8'hFF, 8'h01, 1'b0, 1'b0);
        issue(8'hFF, 8'h00, 1'b0, 1'b1);
        issue(8'h05, 8'h07, 1'b1, 1'b1);
        issue(8'h07, 8'h05, 1'b1, 1'b0);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8'h80, 8'hFF, 1'b0, 1'b0);
        drain();

        // Start while busy is ignored: exactly one done.
        d0 = n_done;
        issue(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (15) @(negedge clk);
        chk("busy_start_one_done", 32'(n_done - d0), 32'd1);

        // Reset in the middle of RUN aborts without a done pulse.
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrun_reset");
        void'(sbq.pop_front());
        rstb = 1'b1;
        d0 = n_done;
        repeat (15) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        issue(8'h33, 8'h44, 1'b0, 1'b0);
        drain();

        // Randomized operations, issued as soon as the DUT is idle.
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();
        repeat (3) @(negedge clk);
        chk("final_hold_sum", 32'(sum), 32'(last_sum));
        chk("final_hold_cout", 32'(cout), 32'(last_cout));
        chk("queue_empty", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rstb  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port: sub  input  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1, cin ignored).
REQ-006 SHALL have ports: a, b  input  WIDTH  operands, captured on start acceptance.
REQ-007 SHALL have port: cin  input  1  carry-in for add mode.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have port: sum  output  WIDTH  result register.
REQ-011 SHALL have port: cout  output  1  final carry-out; in sub mode 1 means no borrow.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 In IDLE with start=1 at an edge, SHALL latch a, b (or ~b if sub), set carry register to cin (or 1 if sub), clear bit counter, and go to RUN.
REQ-014 In RUN, each edge SHALL process one bit LSB-first through a single 1-bit full adder, shift the result bit into sum from the MSB side, update carry register from Co, and increment the counter.
REQ-015 After exactly WIDTH RUN cycles, SHALL go to DONE; cout = final carry.
REQ-016 done SHALL be high only in DONE (one cycle); DONE SHALL return to IDLE unconditionally.
REQ-017 Latency: done asserts WIDTH+1 cycles after the start-accepting edge; the next start is accepted one cycle after done at the earliest.
REQ-018 start while busy (RUN or DONE) SHALL be ignored, with no queueing.
REQ-019 a, b, sub and cin changes after acceptance SHALL NOT affect the operation in progress.
REQ-020 sum and cout SHALL hold their values from DONE until the next accepted start.
REQ-021 All arithmetic SHALL be modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Reset
REQ-022 rstb=0 at an edge SHALL force IDLE and set sum=0, cout=0, done=0, busy=0, counter=0, carry register=0, ovf=0.
REQ-023 Reset asserted mid-RUN SHALL abort the operation without producing a done pulse.
REQ-024 start SHALL be ignored in the cycle that rstb=0 is sampled.

Configuration
REQ-025 With macro SERIAL_ADD_OVF_EN defined, SHALL add port ovf (output, 1 bit): two's-complement signed overflow (carry into MSB XOR carry out of MSB), valid with done and held like sum.
REQ-026 Without SERIAL_ADD_OVF_EN, ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package SHALL hold the FSM state typedef/encoding (IDLE=0, RUN=1, DONE=2) and the default WIDTH constant.
REQ-028 SHALL instantiate exactly one adder_1bit (ports A, B, Ci, Co, S) as its sole datapath sub-module.
REQ-029 Counter width SHALL be clog2(WIDTH+1) bits.

Verification (WIDTH=8)
REQ-030 Add: a=0x2A, b=0x15, cin=0, start pulse -> done at cycle 9, sum=0x3F, cout=0.
REQ-031 Wrap: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1.
REQ-032 Sub: sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; a=0x07, b=0x05 -> sum=0x02, cout=1.
REQ-033 Busy: second start at cycle 3 with different operands -> ignored, first result returned, exactly one done pulse.
REQ-034 Reset at cycle 4 of RUN -> IDLE next cycle, all outputs 0, no done; a new start then completes normally.
REQ-035 With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0xFF -> sum=0x7F, ovf=1, cout=1.
